order_checker: RTL and testbench

Consumer side of the order stream. Buffers 24-bit order words from the order generator in a FIFO, compares each submitted dish word against the oldest pending order, and reports hit, miss or expiry. It also keeps the running game score. Sits between the order generator and the player-input/dish-assembly logic; its outputs drive the display and score logic.

---
 rtl/order_pkg.sv | 49 ++++
 rtl/order_fifo.sv | 63 ++++++
 rtl/order_checker.sv | 124 ++++++++++++
 tb/tb_order_checker.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/order_pkg.sv
// Shared order-word layout, checker FSM states and saturating score arithmetic.
// The order generator packs its words with the same field slices.
package order_pkg;

   localparam int ORDER_W = 24;
   localparam int SCORE_W = 16;
   localparam int CNT_W   = 5;

   localparam int MENU_A_HI = 23;
   localparam int MENU_A_LO = 19;
   localparam int QTY_A_HI  = 18;
   localparam int QTY_A_LO  = 12;
   localparam int MENU_B_HI = 11;
   localparam int MENU_B_LO = 7;
   localparam int QTY_B_HI  = 6;
   localparam int QTY_B_LO  = 0;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      SERVE = 2'd1,
      JUDGE = 2'd2
   } state_e;

   function automatic logic [ORDER_W-1:0] pack_order(input logic [4:0] menu_a,
                                                     input logic [6:0] qty_a,
                                                     input logic [4:0] menu_b,
                                                     input logic [6:0] qty_b);
      logic [ORDER_W-1:0] w;
      w                      = '0;
      w[MENU_A_HI:MENU_A_LO] = menu_a;
      w[QTY_A_HI:QTY_A_LO]   = qty_a;
      w[MENU_B_HI:MENU_B_LO] = menu_b;
      w[QTY_B_HI:QTY_B_LO]   = qty_b;
      return w;
   endfunction

   function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                  input logic [SCORE_W-1:0] b);
      logic [SCORE_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[SCORE_W] ? {SCORE_W{1'b1}} : s[SCORE_W-1:0];
   endfunction

   function automatic logic [SCORE_W-1:0] sat_sub(input logic [SCORE_W-1:0] a,
                                                  input logic [SCORE_W-1:0] b);
      return (a < b) ? '0 : (a - b);
   endfunction

endpackage

// File: rtl/order_fifo.sv
// Synchronous FIFO with first-word-fall-through head and occupancy count.
// Pointers wrap modulo DEPTH, so DEPTH need not be a power of two.
module order_fifo
   import order_pkg::*;
#(
   parameter int DEPTH = 10,
   parameter int WIDTH = ORDER_W
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] head_o,
   output logic             head_valid_o,
   output logic [CNT_W-1:0] count_o,
   output logic             full_o
);
   localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0] LAST     = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             do_push, do_pop;

   assign do_push = push_i && (cnt_q != FULL_CNT);
   assign do_pop  = pop_i && (cnt_q != '0);

   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (do_push) wr_d = (wr_q == LAST) ? '0 : wr_q + PTR_W'(1);
      if (do_pop)  rd_d = (rd_q == LAST) ? '0 : rd_q + PTR_W'(1);
      if (do_push && !do_pop)      cnt_d = cnt_q + CNT_W'(1);
      else if (do_pop && !do_push) cnt_d = cnt_q - CNT_W'(1);
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   // Storage carries no reset; the count alone decides what is valid.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_q] <= data_i;
   end

   assign head_valid_o = (cnt_q != '0);
   assign head_o       = head_valid_o ? mem_q[rd_q] : '0;
   assign count_o      = cnt_q;
   assign full_o       = (cnt_q == FULL_CNT);

endmodule

// File: rtl/order_checker.sv
// Order checker: queues incoming orders, judges each dish against the oldest
// pending order, expires a head that waits too long and keeps a saturating score.
module order_checker
   import order_pkg::*;
#(
   parameter int DEPTH       = 10,
   parameter int TIMEOUT_CYC = 1000,
   parameter int HIT_PTS     = 10,
   parameter int MISS_PTS    = 3,
   parameter int EXP_PTS     = 5
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               ord_valid,
   input  logic [ORDER_W-1:0] ord_data,
   output logic               ord_ready,
   input  logic               dish_valid,
   input  logic [ORDER_W-1:0] dish_data,
   output logic               dish_ready,
   output logic               head_valid,
   output logic [ORDER_W-1:0] head_order,
   output logic [CNT_W-1:0]   pending,
   output logic               result_valid,
   output logic               result_hit,
   output logic               result_expired,
   output logic [SCORE_W-1:0] score
);
   localparam int                 AGE_W    = $clog2(TIMEOUT_CYC);
   localparam logic [AGE_W-1:0]   AGE_LAST = AGE_W'(TIMEOUT_CYC - 1);
   localparam logic [SCORE_W-1:0] HIT_INC  = SCORE_W'(HIT_PTS);
   localparam logic [SCORE_W-1:0] MISS_DEC = SCORE_W'(MISS_PTS);
   localparam logic [SCORE_W-1:0] EXP_DEC  = SCORE_W'(EXP_PTS);

   state_e             state_q;
   logic [AGE_W-1:0]   age_q;
   logic [ORDER_W-1:0] dish_q;
   logic [SCORE_W-1:0] score_q;
   logic               res_valid_q, res_hit_q, res_exp_q;
   logic               fifo_full, push, pop, dish_hs, expire, hit, becomes_empty;

   // Both streams transfer on a cycle where valid and ready are high together;
   // ready never depends on valid, and a source holds valid/data until taken.
   assign ord_ready     = !fifo_full;
   assign push          = ord_valid && ord_ready;
   assign dish_ready    = (state_q == SERVE);
   assign dish_hs       = dish_valid && dish_ready;
   assign expire        = (state_q == SERVE) && !dish_hs && (age_q == AGE_LAST);
   assign hit           = (state_q == JUDGE) && (dish_q == head_order);
   assign pop           = expire || hit;
   assign becomes_empty = (pending == CNT_W'(1)) && !push;

   order_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ORDER_W)
   ) u_fifo (
      .clk_i        (clk),
      .rst_n_i      (rst_n),
      .push_i       (push),
      .data_i       (ord_data),
      .pop_i        (pop),
      .head_o       (head_order),
      .head_valid_o (head_valid),
      .count_o      (pending),
      .full_o       (fifo_full)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= EMPTY;
         age_q       <= '0;
         dish_q      <= '0;
         score_q     <= '0;
         res_valid_q <= 1'b0;
         res_hit_q   <= 1'b0;
         res_exp_q   <= 1'b0;
      end else begin
         res_valid_q <= 1'b0;
         res_hit_q   <= 1'b0;
         res_exp_q   <= 1'b0;
         case (state_q)
            EMPTY: begin
               if (push) begin
                  state_q <= SERVE;
                  age_q   <= '0;
               end
            end
            SERVE: begin
               // The age holds on the accept edge so a miss resumes the same timer.
               if (dish_hs) begin
                  dish_q  <= dish_data;
                  state_q <= JUDGE;
               end else if (expire) begin
                  score_q     <= sat_sub(score_q, EXP_DEC);
                  res_valid_q <= 1'b1;
                  res_exp_q   <= 1'b1;
                  age_q       <= '0;
                  state_q     <= becomes_empty ? EMPTY : SERVE;
               end else begin
                  age_q <= age_q + AGE_W'(1);
               end
            end
            JUDGE: begin
               res_valid_q <= 1'b1;
               if (hit) begin
                  res_hit_q <= 1'b1;
                  score_q   <= sat_add(score_q, HIT_INC);
                  age_q     <= '0;
                  state_q   <= becomes_empty ? EMPTY : SERVE;
               end else begin
                  score_q <= sat_sub(score_q, MISS_DEC);
                  state_q <= SERVE;
               end
            end
            default: state_q <= EMPTY;
         endcase
      end
   end

   assign result_valid   = res_valid_q;
   assign result_hit     = res_hit_q;
   assign result_expired = res_exp_q;
   assign score          = score_q;

endmodule

// File: tb/tb_order_checker.sv
// Directed bench for order_checker with a short timeout so expiry is reachable.
module tb_order_checker;
   import order_pkg::*;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               ord_valid;
   logic [ORDER_W-1:0] ord_data;
   logic               ord_ready;
   logic               dish_valid;
   logic [ORDER_W-1:0] dish_data;
   logic               dish_ready;
   logic               head_valid;
   logic [ORDER_W-1:0] head_order;
   logic [CNT_W-1:0]   pending;
   logic               result_valid;
   logic               result_hit;
   logic               result_expired;
   logic [SCORE_W-1:0] score;

   int checks = 0;
   int errors = 0;
   logic [ORDER_W-1:0] exp_q[$];

   localparam logic [ORDER_W-1:0] ORD_A = 24'h0A0001;
   localparam logic [ORDER_W-1:0] ORD_B = 24'h0B0002;
   localparam logic [ORDER_W-1:0] ORD_C = 24'h0C0003;
   localparam logic [ORDER_W-1:0] ORD_D = 24'h0D0004;

   order_checker #(
      .DEPTH       (10),
      .TIMEOUT_CYC (8),
      .HIT_PTS     (10),
      .MISS_PTS    (3),
      .EXP_PTS     (5)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .ord_valid      (ord_valid),
      .ord_data       (ord_data),
      .ord_ready      (ord_ready),
      .dish_valid     (dish_valid),
      .dish_data      (dish_data),
      .dish_ready     (dish_ready),
      .head_valid     (head_valid),
      .head_order     (head_order),
      .pending        (pending),
      .result_valid   (result_valid),
      .result_hit     (result_hit),
      .result_expired (result_expired),
      .score          (score)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; ord_valid = 1'b0; ord_data = '0; dish_valid = 1'b0; dish_data = '0;
      tick(); tick();
      checks++; if (pending !== 5'd0) begin errors++; $display("FAIL reset_pending: got %0d exp 0", pending); end
      checks++; if (head_valid !== 1'b0) begin errors++; $display("FAIL reset_head_valid: got %b exp 0", head_valid); end
      checks++; if (head_order !== 24'h0) begin errors++; $display("FAIL reset_head_order: got %h exp 000000", head_order); end
      checks++; if (ord_ready !== 1'b1) begin errors++; $display("FAIL reset_ord_ready: got %b exp 1", ord_ready); end
      checks++; if (dish_ready !== 1'b0) begin errors++; $display("FAIL reset_dish_ready: got %b exp 0", dish_ready); end
      checks++; if ({result_valid, result_hit, result_expired} !== 3'b000) begin errors++; $display("FAIL reset_result: got %b exp 000", {result_valid, result_hit, result_expired}); end
      checks++; if (score !== 16'd0) begin errors++; $display("FAIL reset_score: got %0d exp 0", score); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_push();
      ord_valid = 1'b1; ord_data = ORD_A; tick();
      checks++; if (head_valid !== 1'b1 || head_order !== ORD_A) begin errors++; $display("FAIL push_latency: got %b/%h exp 1/%h", head_valid, head_order, ORD_A); end
      ord_data = ORD_B; tick();
      ord_data = ORD_C; tick();
      ord_valid = 1'b0;
      checks++; if (pending !== 5'd3) begin errors++; $display("FAIL push_pending: got %0d exp 3", pending); end
      checks++; if (head_order !== ORD_A) begin errors++; $display("FAIL push_head: got %h exp %h", head_order, ORD_A); end
      checks++; if (ord_ready !== 1'b1) begin errors++; $display("FAIL push_ord_ready: got %b exp 1", ord_ready); end
   endtask

   task automatic test_hit();
      checks++; if (dish_ready !== 1'b1) begin errors++; $display("FAIL hit_dish_ready_serve: got %b exp 1", dish_ready); end
      dish_valid = 1'b1; dish_data = ORD_A; tick();
      dish_valid = 1'b0;
      checks++; if (dish_ready !== 1'b0 || result_valid !== 1'b0) begin errors++; $display("FAIL hit_judge_cycle: got ready=%b valid=%b exp 0/0", dish_ready, result_valid); end
      checks++; if (pending !== 5'd3) begin errors++; $display("FAIL hit_pending_in_judge: got %0d exp 3", pending); end
      tick();
      checks++; if ({result_valid, result_hit, result_expired} !== 3'b110) begin errors++; $display("FAIL hit_result: got %b exp 110", {result_valid, result_hit, result_expired}); end
      checks++; if (score !== 16'd10) begin errors++; $display("FAIL hit_score: got %0d exp 10", score); end
      checks++; if (pending !== 5'd2 || head_order !== ORD_B) begin errors++; $display("FAIL hit_pop: got %0d/%h exp 2/%h", pending, head_order, ORD_B); end
      tick();
      checks++; if (result_valid !== 1'b0 || dish_ready !== 1'b1) begin errors++; $display("FAIL hit_pulse_end: got valid=%b ready=%b exp 0/1", result_valid, dish_ready); end
   endtask

   task automatic test_miss();
      dish_valid = 1'b1; dish_data = 24'h0B0003; tick();
      dish_valid = 1'b0; tick();
      checks++; if ({result_valid, result_hit, result_expired} !== 3'b100) begin errors++; $display("FAIL miss_result: got %b exp 100", {result_valid, result_hit, result_expired}); end
      checks++; if (score !== 16'd7) begin errors++; $display("FAIL miss_score: got %0d exp 7", score); end
      checks++; if (pending !== 5'd2 || head_order !== ORD_B) begin errors++; $display("FAIL miss_head_kept: got %0d/%h exp 2/%h", pending, head_order, ORD_B); end
   endtask

   task automatic test_expiry();
      int got;
      // B's timer ran one cycle before the miss held it, so six more increments then the pop.
      got = 0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (result_valid === 1'b1) begin got = i; break; end
      end
      checks++; if (got != 7) begin errors++; $display("FAIL expiry_b_latency: got %0d exp 7", got); end
      checks++; if (result_expired !== 1'b1 || result_hit !== 1'b0) begin errors++; $display("FAIL expiry_b_flags: got exp=%b hit=%b exp 1/0", result_expired, result_hit); end
      checks++; if (score !== 16'd2) begin errors++; $display("FAIL expiry_b_score: got %0d exp 2", score); end
      checks++; if (pending !== 5'd1 || head_order !== ORD_C) begin errors++; $display("FAIL expiry_b_pop: got %0d/%h exp 1/%h", pending, head_order, ORD_C); end
      got = 0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (result_valid === 1'b1) begin got = i; break; end
      end
      checks++; if (got != 8) begin errors++; $display("FAIL expiry_c_latency: got %0d exp 8", got); end
      checks++; if (result_expired !== 1'b1) begin errors++; $display("FAIL expiry_c_flag: got %b exp 1", result_expired); end
      checks++; if (score !== 16'd0) begin errors++; $display("FAIL expiry_c_score_sat: got %0d exp 0", score); end
      checks++; if (pending !== 5'd0 || head_valid !== 1'b0 || head_order !== 24'h0) begin errors++; $display("FAIL expiry_c_empty: got %0d/%b/%h exp 0/0/000000", pending, head_valid, head_order); end
      checks++; if (dish_ready !== 1'b0) begin errors++; $display("FAIL expiry_c_dish_ready: got %b exp 0", dish_ready); end
   endtask

   task automatic test_miss_zero();
      ord_valid = 1'b1; ord_data = ORD_D; tick();
      ord_valid = 1'b0;
      dish_valid = 1'b1; dish_data = 24'h0D0005; tick();
      dish_valid = 1'b0; tick();
      checks++; if (result_valid !== 1'b1 || result_hit !== 1'b0) begin errors++; $display("FAIL miss0_result: got %b/%b exp 1/0", result_valid, result_hit); end
      checks++; if (score !== 16'd0) begin errors++; $display("FAIL miss0_score_sat: got %0d exp 0", score); end
      dish_valid = 1'b1; dish_data = ORD_D; tick();
      dish_valid = 1'b0; tick();
      checks++; if (result_hit !== 1'b1 || score !== 16'd10) begin errors++; $display("FAIL miss0_rehit: got hit=%b score=%0d exp 1/10", result_hit, score); end
      checks++; if (pending !== 5'd0 || head_valid !== 1'b0) begin errors++; $display("FAIL miss0_empty: got %0d/%b exp 0/0", pending, head_valid); end
   endtask

   task automatic test_full_wrap();
      logic [ORDER_W-1:0] w;
      int n;
      exp_q.delete();
      // A wrong dish held valid while filling keeps the head in SERVE/JUDGE
      // back-to-back, so the short timeout never fires during the fill.
      dish_valid = 1'b1; dish_data = 24'hFFFFFF;
      for (int i = 0; i < 10; i++) begin
         w = pack_order(5'(i + 1), 7'(i + 16), 5'(i + 3), 7'(2 * i + 1));
         ord_valid = 1'b1; ord_data = w; exp_q.push_back(w);
         tick();
      end
      dish_valid = 1'b0;
      ord_data = 24'hEEEEEE;
      checks++; if (pending !== 5'd10 || ord_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %0d/%b exp 10/0", pending, ord_ready); end
      tick();
      checks++; if (result_valid !== 1'b1 || result_hit !== 1'b0 || score !== 16'd0) begin errors++; $display("FAIL full_miss_run: got %b/%b/%0d exp 1/0/0", result_valid, result_hit, score); end
      checks++; if (pending !== 5'd10 || head_order !== exp_q[0]) begin errors++; $display("FAIL full_ignored_push: got %0d/%h exp 10/%h", pending, head_order, exp_q[0]); end
      dish_valid = 1'b1; dish_data = exp_q[0]; tick();
      dish_valid = 1'b0; tick();
      ord_valid = 1'b0;
      void'(exp_q.pop_front());
      checks++; if (result_hit !== 1'b1 || score !== 16'd10 || pending !== 5'd9) begin errors++; $display("FAIL full_first_hit: got %b/%0d/%0d exp 1/10/9", result_hit, score, pending); end
      checks++; if (head_order !== exp_q[0]) begin errors++; $display("FAIL full_head_after_hit: got %h exp %h", head_order, exp_q[0]); end
      dish_valid = 1'b1; dish_data = exp_q[0]; tick();
      dish_valid = 1'b0;
      w = pack_order(5'd30, 7'd100, 5'd29, 7'd99);
      ord_valid = 1'b1; ord_data = w; tick();
      ord_valid = 1'b0;
      void'(exp_q.pop_front());
      exp_q.push_back(w);
      checks++; if (result_hit !== 1'b1 || pending !== 5'd9 || score !== 16'd20) begin errors++; $display("FAIL full_pop_push: got %b/%0d/%0d exp 1/9/20", result_hit, pending, score); end
      w = pack_order(5'd31, 7'd127, 5'd1, 7'd2);
      ord_valid = 1'b1; ord_data = w; tick();
      ord_valid = 1'b0;
      exp_q.push_back(w);
      checks++; if (pending !== 5'd10 || ord_ready !== 1'b0) begin errors++; $display("FAIL full_refill: got %0d/%b exp 10/0", pending, ord_ready); end
      n = 0;
      while (exp_q.size() > 0 && n < 20) begin
         n++;
         checks++; if (head_order !== exp_q[0]) begin errors++; $display("FAIL wrap_order_%0d: got %h exp %h", n, head_order, exp_q[0]); end
         dish_valid = 1'b1; dish_data = exp_q[0]; tick();
         dish_valid = 1'b0; tick();
         checks++; if (result_hit !== 1'b1) begin errors++; $display("FAIL wrap_hit_%0d: got %b exp 1", n, result_hit); end
         void'(exp_q.pop_front());
      end
      checks++; if (score !== 16'd120 || pending !== 5'd0 || head_valid !== 1'b0) begin errors++; $display("FAIL wrap_drained: got %0d/%0d/%b exp 120/0/0", score, pending, head_valid); end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 5; i++) begin
         ord_valid = 1'b1; ord_data = 24'h500000 + 24'(i); tick();
      end
      ord_valid = 1'b0;
      dish_valid = 1'b1; dish_data = 24'h500000; tick();
      dish_valid = 1'b0;
      checks++; if (dish_ready !== 1'b0 || pending !== 5'd5) begin errors++; $display("FAIL rmid_in_judge: got %b/%0d exp 0/5", dish_ready, pending); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (pending !== 5'd0 || head_valid !== 1'b0 || head_order !== 24'h0) begin errors++; $display("FAIL rmid_fifo: got %0d/%b/%h exp 0/0/000000", pending, head_valid, head_order); end
      checks++; if (ord_ready !== 1'b1 || dish_ready !== 1'b0) begin errors++; $display("FAIL rmid_ready: got %b/%b exp 1/0", ord_ready, dish_ready); end
      checks++; if ({result_valid, result_hit, result_expired} !== 3'b000 || score !== 16'd0) begin errors++; $display("FAIL rmid_result_score: got %b/%0d exp 000/0", {result_valid, result_hit, result_expired}, score); end
      tick();
      rst_n = 1'b1;
      tick();
      ord_valid = 1'b1; ord_data = 24'h777777; tick();
      ord_valid = 1'b0;
      checks++; if (pending !== 5'd1 || head_order !== 24'h777777) begin errors++; $display("FAIL rmid_repush: got %0d/%h exp 1/777777", pending, head_order); end
      dish_valid = 1'b1; dish_data = 24'h777777; tick();
      dish_valid = 1'b0; tick();
      checks++; if (result_hit !== 1'b1 || score !== 16'd10 || pending !== 5'd0) begin errors++; $display("FAIL rmid_rehit: got %b/%0d/%0d exp 1/10/0", result_hit, score, pending); end
   endtask

   initial begin
      test_reset();
      test_push();
      test_hit();
      test_miss();
      test_expiry();
      test_miss_zero();
      test_full_wrap();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

endmodule
